// File: rtl/fb_pkg.sv
// fb_pkg -- shared definitions for the dual-port frame buffer.
//   Default resolution and pixel width, pixel type, the clear-engine
//   state encoding and the (x,y) -> linear address mapping.
package fb_pkg;

  localparam int FB_H_RES   = 640;
  localparam int FB_V_RES   = 480;
  localparam int FB_PIXEL_W = 8;

  typedef logic [FB_PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Row-major linear address; callers truncate to their RAM address width.
  function automatic int unsigned fb_lin_addr(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned h_res);
    return y * h_res + x;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// fb_ram -- inferred simple dual-port RAM, one write port and one
// registered read port on a single clock. No control logic.
// A read and a write to the same address on the same edge return the
// old contents (read-first).
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (rdata holds when low)
//   raddr  in   read address
//   rdata  out  registered read data
module fb_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_dp.sv
// frame_buffer_dp -- dual-port pixel store between the pong draw logic
// and VGA scan-out. (x,y) addressed write port with valid/ready, read
// port with fixed 2-cycle latency and a valid flag, and a clear-screen
// engine that fills the whole frame with one colour.
//
// Optional feature (define FB_DOUBLE_BUFFER_EN): two frame halves; reads
// come from the front half, writes/clears go to the back half, and a
// requested swap is applied on frame_start once no clear is running.
//
// Ports:
//   VGA_CLK      in   clock, all logic on rising edge
//   RST          in   asynchronous active-high reset
//   wr_valid     in   write request
//   wr_ready     out  write port can accept (low while clearing / in reset)
//   wr_x, wr_y   in   write coordinate
//   wr_pixel     in   write data
//   rd_en        in   read request
//   rd_x, rd_y   in   read coordinate
//   rd_pixel     out  read data, 2 cycles after rd_en
//   rd_valid     out  rd_pixel valid this cycle
//   clear_req    in   start a clear (level sampled while idle)
//   clear_color  in   fill colour, captured when the clear starts
//   clear_busy   out  clear in progress
//   swap_req     in   (FB_DOUBLE_BUFFER_EN) request a buffer swap
//   swap_pending out  (FB_DOUBLE_BUFFER_EN) swap requested, not yet applied
//   frame_start  in   one-cycle pulse at start of VGA frame
module frame_buffer_dp
  import fb_pkg::*;
#(
  parameter int                 H_RES    = FB_H_RES,
  parameter int                 V_RES    = FB_V_RES,
  parameter int                 PIXEL_W  = FB_PIXEL_W,
  parameter logic [PIXEL_W-1:0] BG_COLOR = '0,
  localparam int                X_W      = $clog2(H_RES),
  localparam int                Y_W      = $clog2(V_RES)
) (
  input  logic               VGA_CLK,
  input  logic               RST,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [X_W-1:0]     wr_x,
  input  logic [Y_W-1:0]     wr_y,
  input  logic [PIXEL_W-1:0] wr_pixel,
  input  logic               rd_en,
  input  logic [X_W-1:0]     rd_x,
  input  logic [Y_W-1:0]     rd_y,
  output logic [PIXEL_W-1:0] rd_pixel,
  output logic               rd_valid,
  input  logic               clear_req,
  input  logic [PIXEL_W-1:0] clear_color,
  output logic               clear_busy,
`ifdef FB_DOUBLE_BUFFER_EN
  input  logic               swap_req,
  output logic               swap_pending,
`endif
  input  logic               frame_start
);

  localparam int DEPTH = H_RES * V_RES;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int RAM_DEPTH = 2 * DEPTH;
`else
  localparam int RAM_DEPTH = DEPTH;
`endif
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  // Half-buffer base offsets for the read and write sides.
  int unsigned rd_base, wr_base;

`ifdef FB_DOUBLE_BUFFER_EN
  logic front_sel;

  // A swap never happens mid-clear: the back half must be complete first.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (frame_start && swap_pending && !clear_busy) begin
      front_sel    <= !front_sel;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  assign rd_base = front_sel ? DEPTH : 0;
  assign wr_base = front_sel ? 0 : DEPTH;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign rd_base = 0;
  assign wr_base = 0;
`endif

  // ---------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------
  clr_state_t          state;
  logic [CW-1:0]       clr_cnt;
  logic [PIXEL_W-1:0]  clr_color;
  logic                ready_q;

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      clr_color <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            clr_color <= clear_color;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CNT_LAST) state <= ST_IDLE;
          clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clear_busy = (state == ST_CLEAR);
  assign wr_ready   = ready_q && !clear_busy;

  // ---------------------------------------------------------------------
  // Write stage: one registered slot feeding the RAM write port.
  // Both accepted user writes and clear pixels pass through it, so a user
  // write accepted on the clear_req edge lands one edge before the first
  // clear pixel, and the last clear pixel lands the cycle after
  // clear_busy drops -- where a new user write can only be in this slot.
  // ---------------------------------------------------------------------
  logic               wr_in_range;
  logic               wq_vld;
  logic [AW-1:0]      wq_addr;
  logic [PIXEL_W-1:0] wq_data;

  assign wr_in_range = (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES);

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      wq_vld  <= 1'b0;
      wq_addr <= '0;
      wq_data <= '0;
    end else if (state == ST_CLEAR) begin
      wq_vld  <= 1'b1;
      wq_addr <= AW'(32'(clr_cnt) + wr_base);
      wq_data <= clr_color;
    end else begin
      // Out-of-range writes are accepted but never reach the RAM.
      wq_vld  <= wr_valid && wr_ready && wr_in_range;
      wq_addr <= AW'(fb_lin_addr(32'(wr_x), 32'(wr_y), H_RES) + wr_base);
      wq_data <= wr_pixel;
    end
  end

  // ---------------------------------------------------------------------
  // Read pipe: stage 0 registers the address, stage 1 is the RAM read.
  // ---------------------------------------------------------------------
  logic               rd_in_range;
  logic [1:0]         rd_vld_pipe;
  logic [1:0]         rd_oor_pipe;
  logic [AW-1:0]      rq_addr;
  logic [PIXEL_W-1:0] ram_q;

  assign rd_in_range = (32'(rd_x) < H_RES) && (32'(rd_y) < V_RES);

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      rd_vld_pipe <= '0;
      rd_oor_pipe <= '0;
      rq_addr     <= '0;
    end else begin
      rd_vld_pipe <= {rd_vld_pipe[0], rd_en};
      rd_oor_pipe <= {rd_oor_pipe[0], !rd_in_range};
      if (rd_en)
        rq_addr <= AW'(fb_lin_addr(32'(rd_x), 32'(rd_y), H_RES) + rd_base);
    end
  end

  fb_ram #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (PIXEL_W)
  ) u_ram (
    .clk   (VGA_CLK),
    .we    (wq_vld),
    .waddr (wq_addr),
    .wdata (wq_data),
    .re    (rd_vld_pipe[0] && !rd_oor_pipe[0]),
    .raddr (rq_addr),
    .rdata (ram_q)
  );

  assign rd_valid = rd_vld_pipe[1];

  // Zero when idle so the output is defined from reset without
  // needing to reset the RAM output register.
  always_comb begin
    rd_pixel = '0;
    if (rd_vld_pipe[1]) rd_pixel = rd_oor_pipe[1] ? BG_COLOR : ram_q;
  end

endmodule

// File: doc/frame_buffer_dp.md
Name: frame_buffer_dp

Overview:
- Parametrised successor of the single-port frame buffer.
- Simple dual-port pixel store: independent write port (game/draw logic) and read port (VGA scan-out) on one clock.
- Adds (x,y) addressing, a valid/ready write handshake, a hardware clear-screen engine and fixed read latency with a valid flag.
- Sits between the pong draw logic and the VGA colour output.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines.
- PIXEL_W, 8, bits per pixel.
- BG_COLOR, 8'h00, value returned for out-of-range reads.
- X_W / Y_W, derived as $clog2(H_RES) / $clog2(V_RES); localparam DEPTH = H_RES*V_RES.

Ports:
- VGA_CLK  in  1  single clock, all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write port can accept.
- wr_x  in  X_W  write column.
- wr_y  in  Y_W  write row.
- wr_pixel  in  PIXEL_W  write data.
- rd_en  in  1  read request.
- rd_x  in  X_W  read column.
- rd_y  in  Y_W  read row.
- rd_pixel  out  PIXEL_W  read data.
- rd_valid  out  1  rd_pixel valid this cycle.
- clear_req  in  1  start clear (level sampled).
- clear_color  in  PIXEL_W  fill value, captured at clear start.
- clear_busy  out  1  clear in progress.
- frame_start  in  1  one-cycle pulse at start of VGA frame (used by the optional feature).

Behaviour:
- Reset values: wr_ready=0 during RST and 1 after; rd_pixel=0; rd_valid=0; clear_busy=0; FSM=IDLE.
- Memory contents are not reset.
- Address = y*H_RES + x, computed in a registered stage (no combinational multiply into the RAM).
- Write handshake:
  - Transfer occurs on a cycle with wr_valid && wr_ready.
  - wr_ready = !clear_busy.
  - Accepted write commits to RAM 1 cycle after acceptance.
  - x>=H_RES or y>=V_RES: still accepted, then silently dropped.
- Read path:
  - Fixed 2-cycle latency, fully pipelined, one read per cycle.
  - rd_en at cycle N gives rd_pixel/rd_valid at N+2.
  - rd_valid=0 in cycles with no matching request.
  - Out-of-range coordinates return BG_COLOR with rd_valid=1 and no RAM access.
- Read/write collision: a read and a commit to the same address in the same cycle return OLD data (read-first).
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clear_req=1: counter := 0, latch clear_color, clear_busy=1 from the next cycle.
  - CLEAR writes one pixel per cycle at address counter; counter increments.
  - After writing DEPTH-1, go to IDLE; clear_busy drops the following cycle. A full clear takes DEPTH cycles.
  - clear_req while busy is ignored. Reads continue unaffected during a clear.
  - A write accepted in the cycle clear_req is sampled still commits before the clear starts.
- RST mid-clear: abort immediately to IDLE; partially cleared contents are left as-is.

Optional Feature:
- Macro: FB_DOUBLE_BUFFER_EN.
- With the macro:
  - RAM depth is 2*DEPTH. A front_sel register (reset 0) chooses the front half.
  - Reads come from the front half; writes and clears go to the back half.
  - Extra input swap_req latches swap_pending; output swap_pending is exposed.
  - On frame_start with swap_pending=1 and clear_busy=0: toggle front_sel and clear swap_pending.
  - If clear_busy=1, the swap waits for the next frame_start.
- Without the macro:
  - Single buffer; swap_req/swap_pending ports are absent; frame_start is ignored.

Decomposition:
- Package fb_pkg holds:
  - default H_RES/V_RES/PIXEL_W;
  - pixel_t typedef;
  - clear FSM state enum (ST_IDLE, ST_CLEAR);
  - function computing the linear address.
- Sub-module fb_ram: inferred simple dual-port RAM (1 write, 1 registered read port), parametrised on depth and width, containing no control logic.

Test Plan:
- Write (10,20)=8'hA5, then read (10,20) -> rd_pixel=8'hA5 with rd_valid exactly 2 cycles after rd_en.
- Write (639,479)=8'h3C, then read it back -> 8'h3C. Write (640,0)=8'hFF -> wr_ready=1, no RAM change. Read (640,0) -> BG_COLOR.
- Same-cycle read and commit to (5,5): old 8'h11 and new 8'h22 -> read returns 8'h11; the next read returns 8'h22.
- clear_req with clear_color=8'h0F:
  - clear_busy high for exactly 307200 cycles and wr_ready=0 throughout.
  - Afterwards, reads of (0,0), (320,240) and (639,479) return 8'h0F.
- Assert RST at clear counter 1000 -> clear_busy=0, rd_valid=0 next edge; address 999 holds 8'h0F; address 1000 keeps its old value.
- With FB_DOUBLE_BUFFER_EN:
  - Write back-buffer (1,1)=8'h77; front still reads the old value.
  - swap_req then frame_start -> front_sel toggles, (1,1) reads 8'h77, swap_pending=0.
